// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - prescaled LED pattern generator with up/down/rotate/ping-pong modes
// A single free-running prescaler qualifies step enables; mode changes and clr reload the pattern.
module led_pattern_engine #(
    parameter int N_LED    = 4,
    parameter int DIV_BASE = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       speed,
    input  logic [1:0]       mode,
    output logic [N_LED-1:0] led,
    output logic             tick,
    output logic             wrap
);
    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_ROT  = 2'b10;
    localparam logic [1:0] MODE_PING = 2'b11;

    localparam logic [N_LED-1:0]    LED_ONE = N_LED'(1);
    localparam logic [DIV_BASE+1:0] PRE_ONE = (DIV_BASE + 2)'(1);

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

    logic [DIV_BASE+1:0] pre_q;
    logic [1:0]          mode_q;
    dir_e                dir_q, dir_d;
    logic [N_LED-1:0]    led_q, led_d, led_init;
    logic                tick_q, wrap_q, wrap_d;
    logic                step_en, reload;

    assign led  = led_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

    assign reload = clr || (mode != mode_q);

    // Each slower rate needs one more low prescaler bit saturated, so boundaries stay phase-aligned.
    always_comb begin
        step_en = 1'b0;
        case (speed)
            2'b01:   step_en = &pre_q[DIV_BASE-1:0];
            2'b10:   step_en = &pre_q[DIV_BASE:0];
            2'b11:   step_en = &pre_q;
            default: step_en = 1'b0;
        endcase
    end

    always_comb begin
        led_init = LED_ONE;
        case (mode)
            MODE_UP:   led_init = '0;
            MODE_DOWN: led_init = '1;
            default:   led_init = LED_ONE;
        endcase
    end

    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        wrap_d = 1'b0;
        case (mode_q)
            MODE_UP: begin
                led_d  = led_q + LED_ONE;
                wrap_d = &led_q;
            end
            MODE_DOWN: begin
                led_d  = led_q - LED_ONE;
                wrap_d = ~|led_q;
            end
            MODE_ROT: begin
                if (~|led_q) begin
                    led_d = LED_ONE;
                end else begin
                    led_d  = {led_q[N_LED-2:0], led_q[N_LED-1]};
                    wrap_d = led_q[N_LED-1];
                end
            end
            default: begin
                // An empty pattern (only reachable through reset) restarts at bit0 without reversing.
                if (~|led_q) begin
                    led_d = LED_ONE;
                end else if (dir_q == DIR_LEFT) begin
                    if (led_q[N_LED-1]) begin
                        led_d  = led_q >> 1;
                        dir_d  = DIR_RIGHT;
                        wrap_d = 1'b1;
                    end else begin
                        led_d = led_q << 1;
                    end
                end else begin
                    if (led_q[0]) begin
                        led_d  = led_q << 1;
                        dir_d  = DIR_LEFT;
                        wrap_d = 1'b1;
                    end else begin
                        led_d = led_q >> 1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            mode_q <= MODE_UP;
            dir_q  <= DIR_LEFT;
            led_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_q + PRE_ONE;
            mode_q <= mode;
            if (reload) begin
                led_q  <= led_init;
                tick_q <= 1'b0;
                wrap_q <= 1'b0;
                if (mode == MODE_PING) begin
                    dir_q <= DIR_LEFT;
                end
            end else if (step_en) begin
                led_q  <= led_d;
                dir_q  <= dir_d;
                tick_q <= 1'b1;
                wrap_q <= wrap_d;
            end else begin
                tick_q <= 1'b0;
                wrap_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - self-checking bench for led_pattern_engine (4- and 8-LED instances)
module tb_led_pattern_engine;
    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [1:0] speed = 2'b01;
    logic [1:0] mode = 2'b00;
    logic [3:0] led4;
    logic [7:0] led8;
    logic       tick4, wrap4, tick8, wrap8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_engine #(.N_LED(4), .DIV_BASE(DB)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .speed(speed), .mode(mode),
        .led(led4), .tick(tick4), .wrap(wrap4)
    );

    led_pattern_engine #(.N_LED(8), .DIV_BASE(DB)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .speed(speed), .mode(mode),
        .led(led8), .tick(tick8), .wrap(wrap8)
    );

    typedef struct packed {
        logic [31:0] led;
        logic        dir;
        logic        wrap;
    } res_t;

    function automatic logic [31:0] pat_init(input logic [1:0] m, input int w);
        if (m == 2'd0) return 32'd0;
        if (m == 2'd1) return (32'd1 << w) - 32'd1;
        return 32'd1;
    endfunction

    // Pattern arithmetic on plain integers; dir 0 means moving toward the MSB.
    function automatic res_t adv(input logic [1:0] m, input int w, input logic [31:0] v, input logic d);
        logic [31:0] modulus, msb;
        res_t r;
        modulus = 32'd1 << w;
        msb     = 32'd1 << (w - 1);
        r.led   = v;
        r.dir   = d;
        r.wrap  = 1'b0;
        case (m)
            2'd0: begin r.led = (v + 1) % modulus; r.wrap = (v == modulus - 1); end
            2'd1: begin r.led = (v + modulus - 1) % modulus; r.wrap = (v == 0); end
            2'd2: begin
                if (v == 0) r.led = 1;
                else begin r.led = ((v * 2) % modulus) + ((v >= msb) ? 1 : 0); r.wrap = (v >= msb); end
            end
            default: begin
                if (v == 0) r.led = 1;
                else if (d == 1'b0) begin
                    if (v >= msb) begin r.led = v / 2; r.dir = 1'b1; r.wrap = 1'b1; end
                    else r.led = v * 2;
                end else begin
                    if (v % 2 == 1) begin r.led = (v * 2) % modulus; r.dir = 1'b0; r.wrap = 1'b1; end
                    else r.led = v / 2;
                end
            end
        endcase
        return r;
    endfunction

    int          mc;
    logic [1:0]  mq;
    logic [31:0] e4, e8;
    logic        d4, d8, et, ew4, ew8;
    res_t        n4, n8;
    int          per;

    assign n4  = adv(mq, 4, e4, d4);
    assign n8  = adv(mq, 8, e8, d8);
    assign per = (speed == 2'd0) ? 0 : (1 << (DB + int'(speed) - 1));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mc <= 0; mq <= 2'd0; e4 <= 0; e8 <= 0; d4 <= 0; d8 <= 0;
            et <= 0; ew4 <= 0; ew8 <= 0;
        end else begin
            mc <= mc + 1;
            mq <= mode;
            if (clr || mode != mq) begin
                e4 <= pat_init(mode, 4);
                e8 <= pat_init(mode, 8);
                if (mode == 2'd3) begin d4 <= 0; d8 <= 0; end
                et <= 0; ew4 <= 0; ew8 <= 0;
            end else if (per != 0 && (mc % per) == per - 1) begin
                e4 <= n4.led; d4 <= n4.dir; ew4 <= n4.wrap;
                e8 <= n8.led; d8 <= n8.dir; ew8 <= n8.wrap;
                et <= 1;
            end else begin
                et <= 0; ew4 <= 0; ew8 <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_led4", 32'(led4), e4);
        chk("model_tick4", 32'(tick4), 32'(et));
        chk("model_wrap4", 32'(wrap4), 32'(ew4));
        chk("model_led8", 32'(led8), e8);
        chk("model_tick8", 32'(tick8), 32'(et));
        chk("model_wrap8", 32'(wrap8), 32'(ew8));
    end

    task automatic wait_tick(output logic [3:0] l4, output logic w4,
                             output logic [7:0] l8, output logic w8, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick4 && n < 200);
        if (!tick4) chk("tick_timeout", 32'(n), 32'd0);
        l4 = led4; w4 = wrap4; l8 = led8; w8 = wrap8;
    endtask

    logic [3:0] pp_led  [0:6] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
    logic       pp_wrap [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [3:0] l4;
        logic [7:0] l8;
        logic       w4, w8;
        int         n, cnt, k;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_led", 32'(led4), 32'd0);
        chk("reset_tick", 32'(tick4), 32'd0);
        chk("reset_wrap", 32'(wrap4), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wait_tick(l4, w4, l8, w8, n);
            chk("up_led", 32'(l4), 32'((i + 1) % 16));
            chk("up_wrap", 32'(w4), 32'(i == 15));
            chk("fast_period", 32'(n), 32'd4);
        end

        speed = 2'b10;
        repeat (2) begin
            wait_tick(l4, w4, l8, w8, n);
            chk("medium_period", 32'(n), 32'd8);
        end
        speed = 2'b11;
        repeat (2) begin
            wait_tick(l4, w4, l8, w8, n);
            chk("slow_period", 32'(n), 32'd16);
        end
        chk("slow_led", 32'(l4), 32'd4);

        speed = 2'b00;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tick4) cnt++;
        end
        chk("hold_ticks", 32'(cnt), 32'd0);
        chk("hold_led", 32'(led4), 32'd4);

        k = 0;
        while ((mc % 16) != 5 && k < 32) begin
            @(negedge clk);
            k++;
        end
        speed = 2'b01;
        wait_tick(l4, w4, l8, w8, n);
        chk("resume_latency", 32'(n), 32'd3);
        chk("resume_led", 32'(l4), 32'd5);

        mode = 2'b11;
        @(negedge clk);
        chk("pp_reload_led", 32'(led4), 32'd1);
        chk("pp_reload_tick", 32'(tick4), 32'd0);
        for (int i = 0; i < 7; i++) begin
            wait_tick(l4, w4, l8, w8, n);
            chk("pp_led", 32'(l4), 32'(pp_led[i]));
            chk("pp_wrap", 32'(w4), 32'(pp_wrap[i]));
        end

        mode = 2'b00;
        @(negedge clk);
        chk("up_reload_led", 32'(led4), 32'd0);
        repeat (5) wait_tick(l4, w4, l8, w8, n);
        chk("up_at_5", 32'(l4), 32'd5);
        mode = 2'b01;
        @(negedge clk);
        chk("down_reload_led", 32'(led4), 32'hf);
        chk("down_reload_tick", 32'(tick4), 32'd0);
        wait_tick(l4, w4, l8, w8, n);
        chk("down_step_led", 32'(l4), 32'he);
        chk("down_step_wrap", 32'(w4), 32'd0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_led", 32'(led4), 32'hf);
        chk("clr_tick", 32'(tick4), 32'd0);
        wait_tick(l4, w4, l8, w8, n);
        chk("after_clr_latency", 32'(n), 32'd4);
        chk("after_clr_led", 32'(l4), 32'he);

        mode = 2'b00;
        @(negedge clk);
        repeat (10) wait_tick(l4, w4, l8, w8, n);
        chk("pre_rst_led", 32'(l4), 32'ha);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led4), 32'd0);
        chk("async_rst_tick", 32'(tick4), 32'd0);
        chk("async_rst_wrap", 32'(wrap4), 32'd0);
        chk("async_rst_led8", 32'(led8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(l4, w4, l8, w8, n);
        chk("post_rst_latency", 32'(n), 32'd4);
        chk("post_rst_led", 32'(l4), 32'd1);

        mode = 2'b10;
        @(negedge clk);
        chk("rot8_reload", 32'(led8), 32'h01);
        for (int i = 0; i < 8; i++) begin
            wait_tick(l4, w4, l8, w8, n);
            chk("rot8_led", 32'(l8), (i < 7) ? (32'd1 << (i + 1)) : 32'd1);
            chk("rot8_wrap", 32'(w8), 32'(i == 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
